// File: rtl/multicycle_adder_pkg.sv
// Shared definitions for the multi-cycle adder: state encoding and sizing helpers.
package adder_pkg;

  // State encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

  // Number of CHUNK-wide slices in a WIDTH-bit operand
  function automatic int unsigned n_chunks(input int unsigned width,
                                           input int unsigned chunk);
    return width / chunk;
  endfunction

  // Chunk counter width: clog2(n), never below one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multicycle_adder_if.sv
// Handshake/bus bundle for multicycle_adder.
//   master: drives start, sub, cin, a, b; observes busy, done, sum, cout, ovf
//   slave : the adder side of the same signals
interface multicycle_adder_if #(
  parameter int unsigned WIDTH = 16
) ();

  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, cin, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, cin, a, b,
    output busy, done, sum, cout, ovf
  );

endinterface

// File: rtl/multicycle_adder_chunk_adder.sv
// Combinational CHUNK-bit ripple adder used once per cycle by multicycle_adder.
//   x, y  : operand slices
//   ci    : carry in
//   s     : slice sum
//   co    : carry out of the top bit
//   c_msb : carry into the top bit (needed for signed overflow on the last slice)
module chunk_adder #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  // Bit-serial ripple through the slice
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign co    = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/multicycle_adder.sv
// Multi-cycle adder/subtractor: adds two WIDTH-bit operands CHUNK bits per
// clock with the carry held in a flop between cycles.
//   clk, rst : clock, synchronous active-high reset
//   bus      : start/sub/cin/a/b in; busy/done/sum/cout/ovf out (all registered)
module multicycle_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic               clk,
  input  logic               rst,
  multicycle_adder_if.slave  bus
);

  localparam int unsigned    N_CHUNKS = n_chunks(WIDTH, CHUNK);
  localparam int unsigned    CW       = cnt_width(N_CHUNKS);
  localparam logic [CW-1:0]  LAST     = CW'(N_CHUNKS - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CHUNK-1:0] x_c, y_c, s_c;
  logic             co_c, cmsb_c;

  // Select the operand slice addressed by the chunk counter
  always_comb begin
    x_c = '0;
    y_c = '0;
    for (int unsigned k = 0; k < N_CHUNKS; k++) begin
      if (cnt_q == CW'(k)) begin
        x_c = a_q[k*CHUNK +: CHUNK];
        y_c = b_q[k*CHUNK +: CHUNK];
      end
    end
  end

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .x     (x_c),
    .y     (y_c),
    .ci    (carry_q),
    .s     (s_c),
    .co    (co_c),
    .c_msb (cmsb_c)
  );

  // Next-state, datapath and output logic
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          // Subtraction is a + ~b + 1: invert b once here, seed carry with 1
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          cnt_d   = '0;
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end

      RUN: begin
        for (int unsigned k = 0; k < N_CHUNKS; k++) begin
          if (cnt_q == CW'(k)) begin
            sum_d[k*CHUNK +: CHUNK] = s_c;
          end
        end
        carry_d = co_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // Top slice: its carries are the MSB carries of the whole word
          cout_d  = co_c;
          ovf_d   = cmsb_c ^ co_c;
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          busy_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// Self-checking bench for multicycle_adder (WIDTH=16, CHUNK=4).
module tb_multicycle_adder;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CHUNK = 4;
  localparam int unsigned NCH   = WIDTH / CHUNK;

  logic clk;
  logic rst;

  multicycle_adder_if #(.WIDTH(WIDTH)) bus ();

  multicycle_adder #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: whole-word arithmetic, result published after NCH busy cycles
  logic        m_busy = 1'b0, m_done = 1'b0, m_cout = 1'b0, m_ovf = 1'b0;
  logic [15:0] m_sum = '0;
  int          m_left = 0;
  logic [15:0] p_sum, p_bb;
  logic        p_cout, p_ovf;
  logic [16:0] p_full;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0; m_left = 0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_sum  = p_sum;
        m_cout = p_cout;
        m_ovf  = p_ovf;
      end
    end else if (bus.start) begin
      p_bb   = bus.sub ? ~bus.b : bus.b;
      p_full = {1'b0, bus.a} + {1'b0, p_bb} + 17'(bus.sub ? 1'b1 : bus.cin);
      p_sum  = p_full[15:0];
      p_cout = p_full[16];
      p_ovf  = (bus.a[15] == p_bb[15]) && (p_full[15] != bus.a[15]);
      m_left = NCH;
      m_busy = 1'b1;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
    end
  end

  // Compare DUT against the model every cycle; sum is only defined outside RUN
  always @(negedge clk) begin
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("done", 32'(bus.done), 32'(m_done));
    chk("cout", 32'(bus.cout), 32'(m_cout));
    chk("ovf",  32'(bus.ovf),  32'(m_ovf));
    if (!m_busy) chk("sum", 32'(bus.sum), 32'(m_sum));
  end

  task automatic drive(input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic ci, input logic st);
    bus.a = a; bus.b = b; bus.sub = s; bus.cin = ci; bus.start = st;
  endtask

  // Launch one operation and check literal results plus timing
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic ci, input logic [15:0] es,
                        input logic eco, input logic eov, input bit noise);
    int lat, busy_n, extra;
    @(negedge clk);
    drive(a, b, s, ci, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    busy_n = bus.busy ? 1 : 0;
    while (!bus.done && lat < 20) begin
      if (noise && lat < 3) drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      else bus.start = 1'b0;
      @(negedge clk);
      lat++;
      if (bus.busy) busy_n++;
    end
    chk({tag, ".done_seen"}, 32'(bus.done), 32'd1);
    chk({tag, ".latency"}, 32'(lat), 32'd5);
    chk({tag, ".busy_cycles"}, 32'(busy_n), 32'd4);
    chk({tag, ".sum"}, 32'(bus.sum), 32'(es));
    chk({tag, ".cout"}, 32'(bus.cout), 32'(eco));
    chk({tag, ".ovf"}, 32'(bus.ovf), 32'(eov));
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
    chk({tag, ".extra_done"}, 32'(extra), 32'd0);
  endtask

  initial begin
    int lat, extra;
    rst = 1'b1;
    drive('0, '0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("reset.busy", 32'(bus.busy), 32'd0);
    chk("reset.done", 32'(bus.done), 32'd0);
    chk("reset.sum",  32'(bus.sum),  32'd0);
    chk("reset.cout", 32'(bus.cout), 32'd0);
    chk("reset.ovf",  32'(bus.ovf),  32'd0);
    rst = 1'b0;

    run_op("add1", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
    run_op("add2", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_op("add3", 16'h7FFF, 16'h0000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_op("sub1", 16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run_op("sub2", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    run_op("noise", 16'h4321, 16'h1111, 1'b0, 1'b0, 16'h5432, 1'b0, 1'b0, 1'b1);

    // Back-to-back: start held high through DONE with new operands
    @(negedge clk);
    drive(16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    lat = 1;
    while (!bus.done && lat < 20) begin
      if (lat == 2) begin bus.a = 16'h0001; bus.b = 16'h0001; end
      @(negedge clk);
      lat++;
    end
    chk("b2b.first_latency", 32'(lat), 32'd5);
    chk("b2b.first_sum", 32'(bus.sum), 32'h2233);
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b.second_latency", 32'(lat), 32'd5);
    chk("b2b.second_sum", 32'(bus.sum), 32'h0002);
    chk("b2b.second_cout", 32'(bus.cout), 32'd0);

    // Reset in the third RUN cycle aborts the operation
    repeat (2) @(negedge clk);
    drive(16'hABCD, 16'h1357, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort.busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort.busy", 32'(bus.busy), 32'd0);
    chk("abort.done", 32'(bus.done), 32'd0);
    chk("abort.sum",  32'(bus.sum),  32'd0);
    chk("abort.cout", 32'(bus.cout), 32'd0);
    chk("abort.ovf",  32'(bus.ovf),  32'd0);
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
    chk("abort.no_done", 32'(extra), 32'd0);
    run_op("after_abort", 16'h00FF, 16'h0F01, 1'b0, 1'b1, 16'h1001, 1'b0, 1'b0, 1'b0);

    // Random traffic against the model, with corner operands and occasional reset
    repeat (2000) begin
      @(negedge clk);
      bus.start = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 5))
        0:       bus.a = 16'hFFFF;
        1:       bus.a = 16'h8000;
        2:       bus.a = 16'h7FFF;
        default: bus.a = 16'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       bus.b = 16'h0000;
        1:       bus.b = 16'h0001;
        2:       bus.b = 16'h8000;
        default: bus.b = 16'($urandom);
      endcase
      bus.sub = 1'($urandom);
      bus.cin = 1'($urandom);
      rst     = ($urandom_range(0, 149) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    repeat (10) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
